// File: rtl/branch_unit_pkg.sv
// Shared definitions for the branch unit: FSM encodings, SPR selects,
// instruction field positions and helpers that pull Power-numbered fields.
package branch_unit_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_EVAL = 2'd1;
    localparam state_t ST_DONE = 2'd2;

    localparam logic [1:0] SPR_LR  = 2'b00;
    localparam logic [1:0] SPR_CTR = 2'b01;
    localparam logic [1:0] SPR_TAR = 2'b10;

    localparam int unsigned BO_POS = 6;
    localparam int unsigned BI_POS = 11;
    localparam int unsigned BD_POS = 16;
    localparam int unsigned LI_POS = 6;
    localparam int unsigned AA_POS = 30;
    localparam int unsigned LK_POS = 31;

    localparam logic [9:0] XO_BCLR  = 10'd16;
    localparam logic [9:0] XO_BCCTR = 10'd528;
    localparam logic [9:0] XO_BCTAR = 10'd560;

    // Power numbering puts a field's MSB at its lowest bit index, so fields are bit-reversed
    function automatic logic [4:0] get_bi(input logic [31:6] f);
        logic [4:0] v;
        v = 5'd0;
        for (int j = 0; j < 5; j++) v[4-j] = f[BI_POS+j];
        return v;
    endfunction

    function automatic logic [13:0] get_bd(input logic [31:6] f);
        logic [13:0] v;
        v = 14'd0;
        for (int j = 0; j < 14; j++) v[13-j] = f[BD_POS+j];
        return v;
    endfunction

    function automatic logic [23:0] get_li(input logic [31:6] f);
        logic [23:0] v;
        v = 24'd0;
        for (int j = 0; j < 24; j++) v[23-j] = f[LI_POS+j];
        return v;
    endfunction

    function automatic logic onehot5(input logic [4:0] v);
        logic [2:0] cnt;
        cnt = 3'd0;
        for (int j = 0; j < 5; j++) cnt = cnt + {2'd0, v[j]};
        return (cnt == 3'd1);
    endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational branch condition: CTR decrement/test and CR bit test.
module branch_cond_eval
    import branch_unit_pkg::*;
(
    input  logic [4:0]  bo,
    input  logic [4:0]  bi,
    input  logic [31:0] cr,
    input  logic [63:0] ctr,
    input  logic        iform,
    input  logic        bform,
    input  logic        cond_lr,
    input  logic        cond_ctr,
    input  logic        cond_tar,
    output logic        ctr_dec,
    output logic [63:0] ctr_new,
    output logic        taken
);

    logic ctr_ok_s;
    logic cond_ok_s;

    // bo[n] holds BO_n; bcctr never decrements CTR
    always_comb begin
        ctr_dec   = ~bo[2] & (bform | cond_lr | cond_tar);
        ctr_new   = ctr_dec ? (ctr - 64'd1) : ctr;
        ctr_ok_s  = bo[2] | ((ctr_new != 64'd0) ^ bo[3]);
        cond_ok_s = bo[0] | (cr[bi] == bo[1]);
        if (iform) begin
            taken = 1'b1;
        end else if (cond_ctr) begin
            taken = cond_ok_s;
        end else begin
            taken = ctr_ok_s & cond_ok_s;
        end
    end

endmodule

// File: rtl/branch_unit.sv
// Branch execution unit: owns LR/CTR/TAR, resolves one branch per request and
// hands the next instruction address back through a valid/ack handshake.
module branch_unit
    import branch_unit_pkg::*;
#(
    parameter logic [63:0] RESET_LR  = 64'h0,
    parameter logic [63:0] RESET_CTR = 64'h0,
    parameter logic [63:0] RESET_TAR = 64'h0
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_en,
    input  logic [31:0] i_instr,
    input  logic        i_i_form,
    input  logic        i_b_form,
    input  logic        i_cond_LR,
    input  logic        i_cond_CTR,
    input  logic        i_cond_TAR,
    input  logic [63:0] i_cia,
    input  logic [31:0] i_cr,
    output logic        o_ready,
    output logic        o_valid,
    input  logic        i_ack,
    output logic        o_taken,
    output logic [63:0] o_nia,
    output logic        o_illegal,
    input  logic        i_spr_we,
    input  logic [1:0]  i_spr_sel,
    input  logic [63:0] i_spr_wdata,
    output logic [63:0] o_lr,
    output logic [63:0] o_ctr,
    output logic [63:0] o_tar
);

    state_t      state_r, next_state_s;
    logic [31:6] fields_r;
    logic [4:0]  form_r;
    logic [63:0] cia_r, lr_r, ctr_r, tar_r, nia_r;
    logic [31:0] cr_r;
    logic        taken_r, illegal_r, valid_r, ready_r;

    logic [4:0]  bo_s, bi_s;
    logic [23:0] li_s;
    logic [13:0] bd_s;
    logic        aa_s, lk_s, ctr_dec_s, taken_s, illegal_s;
    logic [63:0] ctr_new_s, base_s, target_s, seq_nia_s, result_nia_s;
    logic        unused_opcode_s;

    assign unused_opcode_s = &{1'b0, i_instr[5:0]};

    assign bo_s = fields_r[BO_POS+4:BO_POS];
    assign bi_s = get_bi(fields_r);
    assign li_s = get_li(fields_r);
    assign bd_s = get_bd(fields_r);
    assign aa_s = fields_r[AA_POS];
    assign lk_s = fields_r[LK_POS];

    branch_cond_eval u_cond (
        .bo       (bo_s),
        .bi       (bi_s),
        .cr       (cr_r),
        .ctr      (ctr_r),
        .iform    (form_r[0]),
        .bform    (form_r[1]),
        .cond_lr  (form_r[2]),
        .cond_ctr (form_r[3]),
        .cond_tar (form_r[4]),
        .ctr_dec  (ctr_dec_s),
        .ctr_new  (ctr_new_s),
        .taken    (taken_s)
    );

    // Target is always formed from the pre-update LR/CTR
    always_comb begin
        base_s    = aa_s ? 64'd0 : cia_r;
        seq_nia_s = cia_r + 64'd4;
        if (form_r[0]) begin
            target_s = {{38{li_s[23]}}, li_s, 2'b00} + base_s;
        end else if (form_r[1]) begin
            target_s = {{48{bd_s[13]}}, bd_s, 2'b00} + base_s;
        end else if (form_r[2]) begin
            target_s = lr_r & ~64'd3;
        end else if (form_r[3]) begin
            target_s = ctr_r & ~64'd3;
        end else if (form_r[4]) begin
            target_s = tar_r & ~64'd3;
        end else begin
            target_s = seq_nia_s;
        end
        illegal_s = ~onehot5(form_r) | (form_r[3] & ~bo_s[2]);
        if (illegal_s) begin
            result_nia_s = seq_nia_s;
        end else if (taken_s) begin
            result_nia_s = target_s;
        end else begin
            result_nia_s = seq_nia_s;
        end
    end

    // Next-state selection
    always_comb begin
        case (state_r)
            ST_IDLE: next_state_s = i_en ? ST_EVAL : ST_IDLE;
            ST_EVAL: next_state_s = ST_DONE;
            ST_DONE: next_state_s = (valid_r & i_ack) ? ST_IDLE : ST_DONE;
            default: next_state_s = ST_IDLE;
        endcase
    end

    // State and handshake flags; valid rises the cycle after DONE is entered
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_r <= ST_IDLE;
            valid_r <= 1'b0;
            ready_r <= 1'b1;
        end else begin
            state_r <= next_state_s;
            valid_r <= (state_r == ST_DONE) & ~(valid_r & i_ack);
            ready_r <= (next_state_s == ST_IDLE);
        end
    end

    // Request capture
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            fields_r <= '0;
            form_r   <= 5'd0;
            cia_r    <= 64'd0;
            cr_r     <= 32'd0;
        end else if ((state_r == ST_IDLE) && i_en) begin
            fields_r <= i_instr[31:6];
            form_r   <= {i_cond_TAR, i_cond_CTR, i_cond_LR, i_b_form, i_i_form};
            cia_r    <= i_cia;
            cr_r     <= i_cr;
        end
    end

    // Result registers, loaded at the close of EVAL
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            taken_r   <= 1'b0;
            nia_r     <= 64'd0;
            illegal_r <= 1'b0;
        end else if (state_r == ST_EVAL) begin
            taken_r   <= taken_s & ~illegal_s;
            nia_r     <= result_nia_s;
            illegal_r <= illegal_s;
        end
    end

    // SPR file: move-to-SPR writes in IDLE, branch side effects at the close of EVAL
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            lr_r  <= RESET_LR;
            ctr_r <= RESET_CTR;
            tar_r <= RESET_TAR;
        end else if ((state_r == ST_IDLE) && i_spr_we) begin
            case (i_spr_sel)
                SPR_LR:  lr_r  <= i_spr_wdata;
                SPR_CTR: ctr_r <= i_spr_wdata;
                SPR_TAR: tar_r <= i_spr_wdata;
                default: ;
            endcase
        end else if ((state_r == ST_EVAL) && !illegal_s) begin
            if (ctr_dec_s) ctr_r <= ctr_new_s;
            if (lk_s) lr_r <= seq_nia_s;
        end
    end

    assign o_ready   = ready_r;
    assign o_valid   = valid_r;
    assign o_taken   = taken_r;
    assign o_nia     = nia_r;
    assign o_illegal = illegal_r;
    assign o_lr      = lr_r;
    assign o_ctr     = ctr_r;
    assign o_tar     = tar_r;

endmodule

// File: tb/tb_branch_unit.sv
// Scoreboard bench for branch_unit: expected results queued at issue, compared on o_valid.
module tb_branch_unit;

    logic        i_clk = 1'b0;
    logic        i_rst, i_en, i_ack, i_spr_we;
    logic [31:0] i_instr, i_cr;
    logic        i_i_form, i_b_form, i_cond_LR, i_cond_CTR, i_cond_TAR;
    logic [63:0] i_cia, i_spr_wdata;
    logic [1:0]  i_spr_sel;
    logic        o_ready, o_valid, o_taken, o_illegal;
    logic [63:0] o_nia, o_lr, o_ctr, o_tar;

    branch_unit dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_en(i_en), .i_instr(i_instr),
        .i_i_form(i_i_form), .i_b_form(i_b_form), .i_cond_LR(i_cond_LR),
        .i_cond_CTR(i_cond_CTR), .i_cond_TAR(i_cond_TAR), .i_cia(i_cia), .i_cr(i_cr),
        .o_ready(o_ready), .o_valid(o_valid), .i_ack(i_ack), .o_taken(o_taken),
        .o_nia(o_nia), .o_illegal(o_illegal), .i_spr_we(i_spr_we), .i_spr_sel(i_spr_sel),
        .i_spr_wdata(i_spr_wdata), .o_lr(o_lr), .o_ctr(o_ctr), .o_tar(o_tar)
    );

    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic        taken;
        logic [63:0] nia;
        logic        illegal;
    } exp_t;

    localparam logic [4:0] F_I = 5'b00001, F_B = 5'b00010, F_LR = 5'b00100,
                           F_CTR = 5'b01000, F_TAR = 5'b10000;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    exp_t        sb[$];
    exp_t        e;
    int          checks = 0;
    int          errors = 0;
    logic        got_ok, got_taken, got_illegal;
    logic [63:0] got_nia;
    int          got_lat;

    // bo is written with BO_0 as its MSB; Power bit k lands at instr[k]
    function automatic logic [31:0] enc_b(input logic [4:0] bo, input logic [4:0] bi,
                                          input logic [13:0] bd, input logic aa, input logic lk);
        logic [31:0] w;
        w = 32'd0;
        for (int j = 0; j < 5; j++) begin
            w[6+j]  = bo[4-j];
            w[11+j] = bi[4-j];
        end
        for (int j = 0; j < 14; j++) w[16+j] = bd[13-j];
        w[30] = aa;
        w[31] = lk;
        return w;
    endfunction

    function automatic logic [31:0] enc_i(input logic [23:0] li, input logic aa, input logic lk);
        logic [31:0] w;
        w = 32'd0;
        for (int j = 0; j < 24; j++) w[6+j] = li[23-j];
        w[30] = aa;
        w[31] = lk;
        return w;
    endfunction

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic spr_write(input logic [1:0] sel, input logic [63:0] data);
        i_spr_we = 1'b1; i_spr_sel = sel; i_spr_wdata = data;
        tick();
        i_spr_we = 1'b0;
    endtask

    task automatic issue(input logic [31:0] instr, input logic [4:0] fl, input logic [63:0] cia,
                         input logic [31:0] cr, input exp_t ex,
                         input logic we, input logic [1:0] sel, input logic [63:0] wd);
        i_instr = instr; i_cia = cia; i_cr = cr;
        {i_cond_TAR, i_cond_CTR, i_cond_LR, i_b_form, i_i_form} = fl;
        i_spr_we = we; i_spr_sel = sel; i_spr_wdata = wd;
        i_en = 1'b1;
        sb.push_back(ex);
        tick();
        i_en = 1'b0; i_spr_we = 1'b0;
    endtask

    task automatic complete(input logic do_ack);
        got_ok = 1'b0; got_lat = 0;
        for (int n = 1; n <= 20 && !got_ok; n++) begin
            tick();
            if (o_valid === 1'b1) begin
                got_ok = 1'b1; got_lat = n;
                got_taken = o_taken; got_nia = o_nia; got_illegal = o_illegal;
            end
        end
        if (do_ack) begin
            i_ack = 1'b1;
            tick();
            i_ack = 1'b0;
        end
    endtask

    task automatic test_reset();
        checks++;
        if ({o_ready, o_valid, o_taken, o_illegal, o_nia} !== {1'b1, 1'b0, 1'b0, 1'b0, 64'd0}) begin
            errors++;
            $display("FAIL reset_outputs got rdy=%b vld=%b tk=%b ill=%b nia=%h", o_ready, o_valid, o_taken, o_illegal, o_nia);
        end
        checks++;
        if ({o_lr, o_ctr, o_tar} !== {64'd0, 64'd0, 64'd0}) begin
            errors++;
            $display("FAIL reset_sprs got lr=%h ctr=%h tar=%h exp all 0", o_lr, o_ctr, o_tar);
        end
    endtask

    task automatic test_iform();
        issue(enc_i(24'h000040, 1'b0, 1'b1), F_I, 64'h1000, 32'd0, '{1'b1, 64'h1100, 1'b0}, 1'b0, 2'b00, 64'd0);
        checks++;
        if (o_ready !== 1'b0) begin errors++; $display("FAIL iform_busy got ready=%b exp 0", o_ready); end
        complete(1'b1);
        e = sb.pop_front();
        checks++;
        if (got_lat !== 2) begin errors++; $display("FAIL iform_latency got %0d exp 2", got_lat); end
        checks++;
        if ({got_ok, got_taken, got_illegal, got_nia} !== {1'b1, e.taken, e.illegal, e.nia}) begin
            errors++; $display("FAIL iform_result got ok=%b tk=%b ill=%b nia=%h exp nia=%h", got_ok, got_taken, got_illegal, got_nia, e.nia);
        end
        checks++;
        if (o_lr !== 64'h1004) begin errors++; $display("FAIL iform_lr got %h exp 1004", o_lr); end
        // wrap past 2^64 and absolute backward target
        issue(enc_i(24'h000040, 1'b0, 1'b0), F_I, 64'hFFFF_FFFF_FFFF_FFF0, 32'd0, '{1'b1, 64'hF0, 1'b0}, 1'b0, 2'b00, 64'd0);
        complete(1'b1);
        e = sb.pop_front();
        checks++;
        if ({got_ok, got_taken, got_nia} !== {1'b1, e.taken, e.nia}) begin
            errors++; $display("FAIL iform_wrap got ok=%b tk=%b nia=%h exp %h", got_ok, got_taken, got_nia, e.nia);
        end
        issue(enc_i(24'hFFFFF0, 1'b1, 1'b0), F_I, 64'h4000, 32'd0, '{1'b1, 64'hFFFF_FFFF_FFFF_FFC0, 1'b0}, 1'b0, 2'b00, 64'd0);
        complete(1'b1);
        e = sb.pop_front();
        checks++;
        if ({got_ok, got_taken, got_nia} !== {1'b1, e.taken, e.nia}) begin
            errors++; $display("FAIL iform_abs got ok=%b tk=%b nia=%h exp %h", got_ok, got_taken, got_nia, e.nia);
        end
        checks++;
        if (o_lr !== 64'h1004) begin errors++; $display("FAIL iform_nolink got lr=%h exp 1004", o_lr); end
    endtask

    task automatic test_bdnz();
        spr_write(2'b01, 64'd1);
        issue(enc_b(5'b10000, 5'd0, 14'h0010, 1'b0, 1'b0), F_B, 64'h2000, 32'd0, '{1'b0, 64'h2004, 1'b0}, 1'b0, 2'b00, 64'd0);
        complete(1'b1);
        e = sb.pop_front();
        checks++;
        if ({got_ok, got_taken, got_nia, o_ctr} !== {1'b1, e.taken, e.nia, 64'd0}) begin
            errors++; $display("FAIL bdnz_ctr1 got tk=%b nia=%h ctr=%h exp tk=0 nia=2004 ctr=0", got_taken, got_nia, o_ctr);
        end
        issue(enc_b(5'b10000, 5'd0, 14'h0010, 1'b0, 1'b0), F_B, 64'h2000, 32'd0, '{1'b1, 64'h2040, 1'b0}, 1'b0, 2'b00, 64'd0);
        complete(1'b1);
        e = sb.pop_front();
        checks++;
        if ({got_ok, got_taken, got_nia, o_ctr} !== {1'b1, e.taken, e.nia, ONES}) begin
            errors++; $display("FAIL bdnz_ctr0 got tk=%b nia=%h ctr=%h exp tk=1 nia=2040 ctr=all ones", got_taken, got_nia, o_ctr);
        end
    endtask

    task automatic test_bclr_bctar();
        spr_write(2'b00, 64'h3003);
        issue(enc_b(5'b10100, 5'd0, 14'd0, 1'b0, 1'b1), F_LR, 64'h5000, 32'd0, '{1'b1, 64'h3000, 1'b0}, 1'b0, 2'b00, 64'd0);
        complete(1'b1);
        e = sb.pop_front();
        checks++;
        if ({got_ok, got_taken, got_nia, o_lr, o_ctr} !== {1'b1, e.taken, e.nia, 64'h5004, ONES}) begin
            errors++; $display("FAIL bclrl got tk=%b nia=%h lr=%h ctr=%h exp nia=3000 lr=5004", got_taken, got_nia, o_lr, o_ctr);
        end
        spr_write(2'b10, 64'h9007);
        issue(enc_b(5'b10100, 5'd0, 14'd0, 1'b0, 1'b0), F_TAR, 64'h6000, 32'd0, '{1'b1, 64'h9004, 1'b0}, 1'b0, 2'b00, 64'd0);
        complete(1'b1);
        e = sb.pop_front();
        checks++;
        if ({got_ok, got_taken, got_nia, o_lr} !== {1'b1, e.taken, e.nia, 64'h5004}) begin
            errors++; $display("FAIL bctar got tk=%b nia=%h lr=%h exp nia=9004 lr=5004", got_taken, got_nia, o_lr);
        end
    endtask

    task automatic test_bcond_cr();
        issue(enc_b(5'b01100, 5'd2, 14'h3FFE, 1'b0, 1'b0), F_B, 64'h8000, 32'h0000_0004, '{1'b1, 64'h7FF8, 1'b0}, 1'b0, 2'b00, 64'd0);
        complete(1'b1);
        e = sb.pop_front();
        checks++;
        if ({got_ok, got_taken, got_nia} !== {1'b1, e.taken, e.nia}) begin
            errors++; $display("FAIL bc_cr_set got tk=%b nia=%h exp tk=1 nia=%h", got_taken, got_nia, e.nia);
        end
        issue(enc_b(5'b01100, 5'd2, 14'h3FFE, 1'b0, 1'b0), F_B, 64'h8000, 32'hFFFF_FFFB, '{1'b0, 64'h8004, 1'b0}, 1'b0, 2'b00, 64'd0);
        complete(1'b1);
        e = sb.pop_front();
        checks++;
        if ({got_ok, got_taken, got_nia, o_ctr} !== {1'b1, e.taken, e.nia, ONES}) begin
            errors++; $display("FAIL bc_cr_clr got tk=%b nia=%h ctr=%h exp tk=0 nia=8004", got_taken, got_nia, o_ctr);
        end
    endtask

    task automatic test_illegal();
        issue(enc_b(5'b10000, 5'd0, 14'd0, 1'b0, 1'b1), F_CTR, 64'hA000, 32'd0, '{1'b0, 64'hA004, 1'b1}, 1'b0, 2'b00, 64'd0);
        complete(1'b1);
        e = sb.pop_front();
        checks++;
        if ({got_ok, got_taken, got_illegal, got_nia, o_lr, o_ctr} !== {1'b1, e.taken, e.illegal, e.nia, 64'h5004, ONES}) begin
            errors++; $display("FAIL ill_bcctr got tk=%b ill=%b nia=%h lr=%h ctr=%h", got_taken, got_illegal, got_nia, o_lr, o_ctr);
        end
        issue(enc_b(5'b10000, 5'd0, 14'h0010, 1'b0, 1'b1), F_I | F_B, 64'hB000, 32'd0, '{1'b0, 64'hB004, 1'b1}, 1'b0, 2'b00, 64'd0);
        complete(1'b1);
        e = sb.pop_front();
        checks++;
        if ({got_ok, got_taken, got_illegal, got_nia, o_lr, o_ctr} !== {1'b1, e.taken, e.illegal, e.nia, 64'h5004, ONES}) begin
            errors++; $display("FAIL ill_twoflags got tk=%b ill=%b nia=%h lr=%h ctr=%h", got_taken, got_illegal, got_nia, o_lr, o_ctr);
        end
        issue(enc_b(5'b10100, 5'd0, 14'd0, 1'b0, 1'b0), 5'b00000, 64'hC000, 32'd0, '{1'b0, 64'hC004, 1'b1}, 1'b0, 2'b00, 64'd0);
        complete(1'b1);
        e = sb.pop_front();
        checks++;
        if ({got_ok, got_taken, got_illegal, got_nia} !== {1'b1, e.taken, e.illegal, e.nia}) begin
            errors++; $display("FAIL ill_noflags got tk=%b ill=%b nia=%h exp %h", got_taken, got_illegal, got_nia, e.nia);
        end
        issue(enc_b(5'b10100, 5'd0, 14'd0, 1'b0, 1'b1), F_CTR, 64'hD000, 32'd0, '{1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0}, 1'b0, 2'b00, 64'd0);
        complete(1'b1);
        e = sb.pop_front();
        checks++;
        if ({got_ok, got_taken, got_illegal, got_nia, o_lr, o_ctr} !== {1'b1, e.taken, e.illegal, e.nia, 64'hD004, ONES}) begin
            errors++; $display("FAIL bcctrl got tk=%b ill=%b nia=%h lr=%h ctr=%h", got_taken, got_illegal, got_nia, o_lr, o_ctr);
        end
    endtask

    task automatic test_hold_ack();
        issue(enc_i(24'h000004, 1'b0, 1'b0), F_I, 64'h100, 32'd0, '{1'b1, 64'h110, 1'b0}, 1'b0, 2'b00, 64'd0);
        complete(1'b0);
        e = sb.pop_front();
        i_instr = enc_i(24'h000100, 1'b0, 1'b1); i_cia = 64'h77_7000;
        {i_cond_TAR, i_cond_CTR, i_cond_LR, i_b_form, i_i_form} = F_I;
        i_en = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++;
            if ({o_valid, o_ready, o_taken, o_nia} !== {1'b1, 1'b0, e.taken, e.nia}) begin
                errors++; $display("FAIL hold_c%0d got vld=%b rdy=%b tk=%b nia=%h exp nia=%h", k, o_valid, o_ready, o_taken, o_nia, e.nia);
            end
        end
        i_en = 1'b0; i_ack = 1'b1;
        tick();
        i_ack = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++;
            if ({o_valid, o_ready, o_lr} !== {1'b0, 1'b1, 64'hD004}) begin
                errors++; $display("FAIL post_ack_c%0d got vld=%b rdy=%b lr=%h exp vld=0 rdy=1 lr=d004", k, o_valid, o_ready, o_lr);
            end
        end
    endtask

    task automatic test_spr_accept();
        issue(enc_b(5'b10000, 5'd0, 14'h0010, 1'b0, 1'b0), F_B, 64'h2000, 32'd0, '{1'b1, 64'h2040, 1'b0}, 1'b1, 2'b01, 64'd7);
        complete(1'b1);
        e = sb.pop_front();
        checks++;
        if ({got_ok, got_taken, got_nia, o_ctr} !== {1'b1, e.taken, e.nia, 64'd6}) begin
            errors++; $display("FAIL spr_accept got tk=%b nia=%h ctr=%h exp tk=1 nia=2040 ctr=6", got_taken, got_nia, o_ctr);
        end
    endtask

    task automatic test_spr_busy();
        issue(enc_i(24'h000004, 1'b0, 1'b0), F_I, 64'h200, 32'd0, '{1'b1, 64'h210, 1'b0}, 1'b0, 2'b00, 64'd0);
        i_spr_we = 1'b1; i_spr_sel = 2'b10; i_spr_wdata = 64'h1234;
        tick();
        i_spr_we = 1'b0;
        complete(1'b0);
        e = sb.pop_front();
        i_spr_we = 1'b1; i_spr_sel = 2'b00; i_spr_wdata = 64'hDEAD;
        tick();
        i_spr_we = 1'b0; i_ack = 1'b1;
        tick();
        i_ack = 1'b0;
        checks++;
        if ({got_ok, got_nia, o_lr, o_tar} !== {1'b1, e.nia, 64'hD004, 64'h9007}) begin
            errors++; $display("FAIL spr_busy got nia=%h lr=%h tar=%h exp lr=d004 tar=9007", got_nia, o_lr, o_tar);
        end
    endtask

    task automatic test_reset_mid();
        spr_write(2'b01, 64'd5);
        spr_write(2'b00, 64'h44);
        issue(enc_b(5'b10000, 5'd0, 14'h0010, 1'b0, 1'b1), F_B, 64'h2000, 32'd0, '{1'b1, 64'h2040, 1'b0}, 1'b0, 2'b00, 64'd0);
        void'(sb.pop_front());
        i_rst = 1'b0;
        #1;
        checks++;
        if ({o_valid, o_ready, o_ctr, o_lr, o_tar} !== {1'b0, 1'b1, 64'd0, 64'd0, 64'd0}) begin
            errors++; $display("FAIL reset_eval got vld=%b rdy=%b ctr=%h lr=%h tar=%h", o_valid, o_ready, o_ctr, o_lr, o_tar);
        end
        tick(); tick();
        i_rst = 1'b1;
        tick();
        issue(enc_i(24'h000004, 1'b0, 1'b0), F_I, 64'h300, 32'd0, '{1'b1, 64'h310, 1'b0}, 1'b0, 2'b00, 64'd0);
        complete(1'b0);
        void'(sb.pop_front());
        #2;
        i_rst = 1'b0;
        #1;
        checks++;
        if ({got_ok, o_valid, o_nia} !== {1'b1, 1'b0, 64'd0}) begin
            errors++; $display("FAIL reset_done got seen=%b vld=%b nia=%h exp seen=1 vld=0 nia=0", got_ok, o_valid, o_nia);
        end
        tick();
        i_rst = 1'b1;
        tick();
        issue(enc_i(24'h000004, 1'b0, 1'b1), F_I, 64'h400, 32'd0, '{1'b1, 64'h410, 1'b0}, 1'b0, 2'b00, 64'd0);
        complete(1'b1);
        e = sb.pop_front();
        checks++;
        if ({got_ok, got_taken, got_nia, o_lr} !== {1'b1, e.taken, e.nia, 64'h404}) begin
            errors++; $display("FAIL reset_recover got tk=%b nia=%h lr=%h exp nia=410 lr=404", got_taken, got_nia, o_lr);
        end
    endtask

    initial begin
        i_rst = 1'b0; i_en = 1'b0; i_ack = 1'b0; i_spr_we = 1'b0;
        i_instr = 32'd0; i_cr = 32'd0; i_cia = 64'd0; i_spr_wdata = 64'd0; i_spr_sel = 2'b11;
        {i_cond_TAR, i_cond_CTR, i_cond_LR, i_b_form, i_i_form} = 5'b00000;
        tick(); tick();
        test_reset();
        i_rst = 1'b1;
        tick();
        test_reset();
        test_iform();
        test_bdnz();
        test_bclr_bctar();
        test_bcond_cr();
        test_illegal();
        test_hold_ack();
        test_spr_accept();
        test_spr_busy();
        test_reset_mid();
        checks++;
        if (sb.size() !== 0) begin errors++; $display("FAIL scoreboard_left got %0d exp 0", sb.size()); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_unit.md
Name: branch_unit

Overview:
Executes the branch instructions that the instruction-identification stage steers to it: I-form, B-form, bclr, bcctr and bctar.
- Owns the LR, CTR and TAR special registers.
- Evaluates the CTR and CR conditions, computes the target and next instruction address, and applies the LR/CTR side effects.
- Sits after instruction identification, consumes its branch-unit outputs, and returns a resolved next-instruction address to fetch through a valid/ack handshake.

Parameters:
RESET_LR, 64'h0, reset value of LR
RESET_CTR, 64'h0, reset value of CTR
RESET_TAR, 64'h0, reset value of TAR

Ports:
i_clk  in  1  clock
i_rst  in  1  reset, asynchronous, active-low (0 = reset)
i_en  in  1  branch request valid; taken only when o_ready=1
i_instr  in  32  instruction; Power bit k is at i_instr[k], and a field's MSB sits at its lowest index
i_i_form / i_b_form / i_cond_LR / i_cond_CTR / i_cond_TAR  in  1 each  form flags from identification
i_cia  in  64  address of the instruction
i_cr  in  32  condition register; CR bit k is at i_cr[k]
o_ready  out  1  unit can accept a request
o_valid  out  1  result valid, held until acknowledged
i_ack  in  1  consumer takes the result
o_taken  out  1  branch taken
o_nia  out  64  next instruction address (target if taken, else CIA+4)
o_illegal  out  1  request was invalid
i_spr_we  in  1  SPR write from the move-to-SPR path
i_spr_sel  in  2  00=LR, 01=CTR, 10=TAR, 11=no-op
i_spr_wdata  in  64  SPR write data
o_lr / o_ctr / o_tar  out  64 each  current SPR values

Behaviour:
- Reset (i_rst=0, asynchronous):
  - state IDLE; LR/CTR/TAR = RESET_*; all latched fields = 0.
  - o_valid=0, o_taken=0, o_illegal=0, o_nia=0, o_ready=1.
- FSM IDLE -> EVAL -> DONE -> IDLE. o_ready = (state==IDLE).
- IDLE: on i_en=1, latch instr, flags, cia and cr; go to EVAL. i_en is ignored in any other state.
- EVAL lasts one cycle. At its closing edge the unit registers o_taken, o_nia and o_illegal, updates LR/CTR, and moves to DONE.
  - Accept edge t gives o_valid=1 from edge t+2.
- DONE: o_valid=1 and the outputs are held stable. On i_ack=1 go to IDLE (o_valid=0 next cycle). i_ack outside DONE is ignored.
- Fields:
  - BO = instr[6:10], BI = instr[11:15], LI = instr[6:29], BD = instr[16:29], AA = instr[30], LK = instr[31].
  - BO_n is BO bit n, with BO_0 = instr[6].
- Condition:
  - ctr_dec = ~BO_2, applied to B-form, bclr and bctar.
  - ctr_ok = BO_2 | ((CTR_new != 0) ^ BO_3), where CTR_new = CTR-1 (mod 2^64) if ctr_dec, else CTR.
  - cond_ok = BO_0 | (cr[BI] == BO_1).
  - I-form is always taken. bcctr uses cond_ok only. All other forms use ctr_ok & cond_ok.
- Target:
  - I-form: EXTS(LI||00) + (AA ? 0 : cia).
  - B-form: EXTS(BD||00) + (AA ? 0 : cia).
  - bclr: LR & ~3. bcctr: CTR & ~3. bctar: TAR & ~3.
  - All address arithmetic wraps mod 2^64.
- Side effects at the end of EVAL: CTR <= CTR_new if ctr_dec. If LK=1, LR <= cia+4, taken or not.
  - The target is computed from the pre-update LR/CTR, so bclrl uses the old LR.
- o_illegal=1 in these cases:
  - the number of set form flags is not exactly 1;
  - bcctr with BO_2=0.
  - An illegal request gives o_taken=0, o_nia=cia+4 and no SPR updates, but still completes the full handshake.
- SPR write:
  - Honoured only in IDLE; ignored in EVAL and DONE.
  - If it coincides with accepting a request, the write lands first and EVAL sees the new value.
- Reset mid-operation aborts the request: no SPR update, and o_valid drops asynchronously.

Decomposition:
- Shared package holds:
  - state enum (IDLE, EVAL, DONE);
  - SPR select constants (SPR_LR, SPR_CTR, SPR_TAR);
  - field-position constants (BO, BI, BD, LI, AA, LK);
  - extended-opcode constants 16, 528 and 560.
- One sub-module, branch_cond_eval: purely combinational; computes ctr_dec, CTR_new, ctr_ok, cond_ok and taken from BO, BI, CR, CTR and the form flags.

Test Plan:
- I-form, LI giving offset +0x100, AA=0, LK=1, cia=0x1000 -> o_valid at accept+2, o_taken=1, o_nia=0x1100, LR=0x1004.
- bdnz (B-form, BO=10000), CTR=1, cia=0x2000 -> CTR=0, o_taken=0, o_nia=0x2004. Repeat with CTR=0 -> CTR=0xFFFF_FFFF_FFFF_FFFF, taken.
- bclrl, BO=10100, LR=0x3003, cia=0x5000 -> o_nia=0x3000 (old LR, low bits cleared), then LR=0x5004.
- B-form BO=01100, BI=2: with i_cr[2]=1 -> taken; with i_cr[2]=0 -> not taken, CTR unchanged.
- bcctr with BO_2=0, and separately i_i_form=i_b_form=1 -> o_illegal=1, o_nia=cia+4, LR/CTR unchanged.
- Handshake and SPR cases:
  - hold i_ack=0 for 5 cycles -> outputs stable, o_ready=0, i_en ignored;
  - SPR write of CTR=7 in the accept cycle -> EVAL uses 7;
  - SPR write during DONE -> ignored;
  - i_rst=0 during EVAL -> o_valid=0 immediately and SPRs return to RESET_*.
